// File: rtl/ir_filters_pkg.sv
// Shared constants and helpers for the IR filter datapath.
// Lane helpers keep pixel slicing consistent across the median blocks.
package ir_filters_pkg;

    localparam int MEDIAN_MAX_PIX = 9;

    // Bit offset of pixel lane idx in a packed column of width-bit pixels.
    function automatic int lane(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/median_cmp_swap.sv
// One compare-exchange cell of the column sorter: purely combinational.
// Equal values are never swapped, so ties keep their lanes.
module median_cmp_swap #(
    parameter int DATA_WIDTH = 8,
    parameter bit DESCENDING = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] lo_in,
    input  logic [DATA_WIDTH-1:0] hi_in,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic [DATA_WIDTH-1:0] hi_out
);

    logic swap;

    // DESCENDING puts the larger value in the higher lane, so the top lane ends up largest.
    always_comb begin
        swap   = DESCENDING ? (lo_in > hi_in) : (lo_in < hi_in);
        lo_out = swap ? hi_in : lo_in;
        hi_out = swap ? lo_in : hi_in;
    end

endmodule

// File: rtl/median_col_sort_pipe.sv
// Fully pipelined odd-even transposition sorter for one median-window column.
// One registered stage per network layer; a single global advance enable stalls every stage together.
module median_col_sort_pipe
    import ir_filters_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PIX    = 3,
    parameter bit DESCENDING = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PIX*DATA_WIDTH-1:0] win_data,
    input  logic                          win_val,
    output logic                          win_rdy,
    input  logic                          win_sol,
    input  logic                          win_eol,
    input  logic                          win_sof,
    input  logic                          win_eof,
    output logic [NUM_PIX*DATA_WIDTH-1:0] sort_data,
    output logic [DATA_WIDTH-1:0]         sort_med,
    output logic                          sort_val,
    input  logic                          sort_rdy,
    output logic                          sort_sol,
    output logic                          sort_eol,
    output logic                          sort_sof,
    output logic                          sort_eof
);

    localparam int W = NUM_PIX * DATA_WIDTH;

    typedef struct packed {
        logic         val;
        logic [W-1:0] data;
        logic         sol;
        logic         eol;
        logic         sof;
        logic         eof;
    } stage_t;

    if ((NUM_PIX % 2 == 0) || (NUM_PIX < 3) || (NUM_PIX > MEDIAN_MAX_PIX)) begin : g_bad_num_pix
        $error("median_col_sort_pipe: NUM_PIX must be odd and within 3..%0d", MEDIAN_MAX_PIX);
    end

    stage_t stage_out [NUM_PIX];
    stage_t last;
    logic   en;

    assign last    = stage_out[NUM_PIX-1];
    // Bubbles are not squeezed: the whole pipe advances only when the output slot is free or taken.
    assign en      = ~last.val | sort_rdy;
    assign win_rdy = en;

    for (genvar s = 0; s < NUM_PIX; s++) begin : g_stage
        localparam int FIRST = s % 2;
        localparam int PASS  = (s % 2 == 0) ? NUM_PIX - 1 : 0;

        stage_t       prev;
        stage_t       st_d;
        stage_t       st_q;
        logic [W-1:0] cmp_out;

        if (s == 0) begin : g_src_in
            assign prev = '{val: win_val, data: win_data, sol: win_sol,
                            eol: win_eol, sof: win_sof, eof: win_eof};
        end else begin : g_src_prev
            assign prev = stage_out[s-1];
        end

        for (genvar p = 0; p < NUM_PIX / 2; p++) begin : g_pair
            localparam int I = FIRST + 2 * p;
            median_cmp_swap #(
                .DATA_WIDTH (DATA_WIDTH),
                .DESCENDING (DESCENDING)
            ) u_cmp (
                .lo_in  (prev.data[lane(I, DATA_WIDTH) +: DATA_WIDTH]),
                .hi_in  (prev.data[lane(I + 1, DATA_WIDTH) +: DATA_WIDTH]),
                .lo_out (cmp_out[lane(I, DATA_WIDTH) +: DATA_WIDTH]),
                .hi_out (cmp_out[lane(I + 1, DATA_WIDTH) +: DATA_WIDTH])
            );
        end

        // Odd column height leaves exactly one lane unpaired per layer.
        assign cmp_out[lane(PASS, DATA_WIDTH) +: DATA_WIDTH] = prev.data[lane(PASS, DATA_WIDTH) +: DATA_WIDTH];

        always_comb begin
            // NOTE: default to the held value first so no path leaves st_d unassigned (no latch).
            st_d = st_q;
            if (en) begin
                st_d      = prev;
                st_d.data = cmp_out;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: data and sideband are cleared too, not just val, so outputs read zero after reset.
            if (rst) begin
                st_q <= '0;
            end else begin
                // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
                st_q <= st_d;
            end
        end

        assign stage_out[s] = st_q;
    end

    assign sort_data = last.data;
    assign sort_med  = last.data[lane((NUM_PIX - 1) / 2, DATA_WIDTH) +: DATA_WIDTH];
    assign sort_val  = last.val;
    assign sort_sol  = last.sol;
    assign sort_eol  = last.eol;
    assign sort_sof  = last.sof;
    assign sort_eof  = last.eof;

endmodule
